// File: rtl/i2s_sample_feeder.sv
// I2S left-channel receiver feeding one sample at a time to a downstream filter
// through a trigger/ack handshake, with a one-deep pending buffer and sticky error flags.
module i2s_sample_feeder #(
  parameter int unsigned DATA_SIZE   = 24,
  parameter int unsigned HOLD_CYCLES = 6,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i2s_bclk,
  input  logic                        i2s_lrclk,
  input  logic                        i2s_sdata,
  input  logic                        filter_done,
  input  logic                        clear_flags,
  output logic signed [DATA_SIZE-1:0] data_out,
  output logic                        sample_trig,
  output logic                        busy,
  output logic                        overrun,
  output logic                        ack_err
);

  localparam int unsigned BIT_CNT_W = $clog2(DATA_SIZE + 1);
  localparam int unsigned HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TMO_W     = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT_ACK, HOLD} state_t;

  logic [1:0]           bclk_sync, lrclk_sync, sdata_sync;
  logic                 bclk_prev;
  logic                 bclk_rise, lr, sd;

  logic [DATA_SIZE-1:0] shift_reg;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 lr_prev, collecting, word_valid;

  state_t               state;
  logic [DATA_SIZE-1:0] pend;
  logic                 pend_full;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [TMO_W-1:0]     tmo_cnt;

  // Two-flop synchronizers plus bclk edge history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bclk_sync  <= '0;
      lrclk_sync <= '0;
      sdata_sync <= '0;
      bclk_prev  <= 1'b0;
    end else begin
      bclk_sync  <= {bclk_sync[0], i2s_bclk};
      lrclk_sync <= {lrclk_sync[0], i2s_lrclk};
      sdata_sync <= {sdata_sync[0], i2s_sdata};
      bclk_prev  <= bclk_sync[1];
    end
  end

  assign bclk_rise = bclk_sync[1] & ~bclk_prev;
  assign lr        = lrclk_sync[1];
  assign sd        = sdata_sync[1];

  // Left-word deserializer; collection only starts at a delay slot, so a word
  // interrupted by reset is never completed afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_reg  <= '0;
      bit_cnt    <= '0;
      lr_prev    <= 1'b0;
      collecting <= 1'b0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (bclk_rise) begin
        lr_prev <= lr;
        if (lr) begin
          collecting <= 1'b0;
        end else if (lr_prev) begin
          collecting <= 1'b1;
          bit_cnt    <= '0;
        end else if (collecting && (bit_cnt < BIT_CNT_W'(DATA_SIZE))) begin
          shift_reg <= {shift_reg[DATA_SIZE-2:0], sd};
          bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
          if (bit_cnt == BIT_CNT_W'(DATA_SIZE - 1)) word_valid <= 1'b1;
        end
      end
    end
  end

  // Handshake FSM with pending buffer and sticky flags (set beats clear)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      data_out    <= '0;
      sample_trig <= 1'b0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      ack_err     <= 1'b0;
      pend        <= '0;
      pend_full   <= 1'b0;
      hold_cnt    <= '0;
      tmo_cnt     <= '0;
    end else begin
      sample_trig <= 1'b0;
      if (clear_flags) begin
        overrun <= 1'b0;
        ack_err <= 1'b0;
      end
      if (word_valid && (state != IDLE)) begin
        pend      <= shift_reg;
        pend_full <= 1'b1;
        if (pend_full) overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pend_full) begin
            data_out  <= pend;
            pend_full <= word_valid;
            if (word_valid) pend <= shift_reg;
            busy      <= 1'b1;
            state     <= TRIG;
          end else if (word_valid) begin
            data_out <= shift_reg;
            busy     <= 1'b1;
            state    <= TRIG;
          end
        end
        TRIG: begin
          sample_trig <= 1'b1;
          tmo_cnt     <= '0;
          state       <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (filter_done) begin
            hold_cnt <= '0;
            state    <= HOLD;
          end else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
            ack_err <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Randomized bench for i2s_sample_feeder: I2S frame driver, acking filter model,
// word scoreboard and directed scenarios for timeout, overrun, partial words and reset.
module tb_i2s_sample_feeder;

  localparam int unsigned DS   = 24;
  localparam int unsigned HOLD = 6;
  localparam int unsigned TMO  = 250;

  logic                 clk = 1'b0;
  logic                 reset, bclk, lrclk, sdata, filter_done, clear_flags;
  logic signed [DS-1:0] data_out;
  logic [DS-1:0]        dout_u;
  logic                 sample_trig, busy, overrun, ack_err;

  int checks = 0;
  int errors = 0;

  logic          ack_en, sb_en, busy_q;
  logic [DS-1:0] exp_q[$];
  logic [DS-1:0] held, w;
  int            busy_lens[$];
  int            trig_cnt, busy_run, ov_seen, half, t0;

  always #5 clk = ~clk;
  assign dout_u = data_out;

  i2s_sample_feeder #(.DATA_SIZE(DS), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .i2s_bclk(bclk), .i2s_lrclk(lrclk), .i2s_sdata(sdata),
    .filter_done(filter_done), .clear_flags(clear_flags), .data_out(data_out),
    .sample_trig(sample_trig), .busy(busy), .overrun(overrun), .ack_err(ack_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bclk period: data and word select change with the falling edge
  task automatic send_bit(input logic lr, input logic sd);
    @(negedge clk);
    bclk = 1'b0; lrclk = lr; sdata = sd;
    repeat (half) @(negedge clk);
    bclk = 1'b1;
    repeat (half - 1) @(negedge clk);
  endtask

  // Delay slot followed by nbits data bits, MSB first; bits past DS are random filler
  task automatic send_word(input logic lr, input logic [DS-1:0] word, input int nbits);
    send_bit(lr, 1'($urandom));
    for (int i = 0; i < nbits; i++)
      send_bit(lr, (i < int'(DS)) ? word[DS-1-i] : 1'($urandom));
  endtask

  task automatic three_words();
    send_word(1'b0, DS'(1), DS); send_word(1'b1, DS'($urandom), 0);
    send_word(1'b0, DS'(2), DS); send_word(1'b1, DS'($urandom), 0);
    send_word(1'b0, DS'(3), DS); send_word(1'b1, DS'($urandom), 0);
  endtask

  // Filter model: acks one clock after seeing the trigger
  initial begin
    filter_done = 1'b0;
    forever begin
      @(negedge clk);
      filter_done = 1'b0;
      if (sample_trig && ack_en) begin
        @(negedge clk);
        filter_done = 1'b1;
      end
    end
  end

  // Monitor: scoreboard on triggers, data stability and busy window lengths
  initial begin
    busy_q = 1'b0; busy_run = 0; trig_cnt = 0; ov_seen = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_q) held = dout_u;
      if (busy) begin
        check("hold_stable", 64'(dout_u), 64'(held));
        busy_run++;
      end else if (busy_q) begin
        busy_lens.push_back(busy_run);
        busy_run = 0;
      end
      if (sample_trig) begin
        trig_cnt++;
        if (sb_en) begin
          check("sb_avail", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) check("sb_data", 64'(dout_u), 64'(exp_q.pop_front()));
        end
      end
      if (clear_flags && overrun) ov_seen++;
      busy_q = busy;
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"}, 64'(dout_u), 64'(0));
    check({tag, "_trig"}, 64'(sample_trig), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_ovr"}, 64'(overrun), 64'(0));
    check({tag, "_ackerr"}, 64'(ack_err), 64'(0));
  endtask

  initial begin
    reset = 1'b0; bclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; clear_flags = 1'b0;
    ack_en = 1'b1; sb_en = 1'b1; half = 4;
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Full left word with acking filter; right word must be ignored
    send_word(1'b1, DS'($urandom), 4);
    t0 = trig_cnt; busy_lens.delete();
    exp_q.push_back(24'h7FFFFF);
    send_word(1'b0, 24'h7FFFFF, DS);
    send_word(1'b1, 24'h123456, DS);
    repeat (50) @(negedge clk);
    check("w1_data", 64'(dout_u), 64'h7FFFFF);
    check("w1_trigs", 64'(trig_cnt - t0), 64'(1));
    check("w1_busy_n", 64'(busy_lens.size()), 64'(1));
    if (busy_lens.size() > 0) check("w1_busy_len", 64'(busy_lens[0]), 64'(2 + HOLD + 1));
    check("w1_ovr", 64'(overrun), 64'(0));
    check("w1_ackerr", 64'(ack_err), 64'(0));

    // Most negative-but-one sample
    t0 = trig_cnt;
    exp_q.push_back(24'h800001);
    send_word(1'b0, 24'h800001, DS);
    send_word(1'b1, DS'($urandom), DS);
    repeat (50) @(negedge clk);
    check("neg_data", 64'(dout_u), 64'h800001);
    check("neg_signed", {32'd0, int'(data_out)}, {32'd0, 32'hFF800001});
    check("neg_trigs", 64'(trig_cnt - t0), 64'(1));

    // Filter never acks; three quick words overrun the pending slot
    ack_en = 1'b0; sb_en = 1'b0; half = 2; busy_lens.delete(); t0 = trig_cnt;
    three_words();
    repeat (400) @(negedge clk);
    check("tmo_data", 64'(dout_u), 64'(3));
    check("tmo_ackerr", 64'(ack_err), 64'(1));
    check("tmo_ovr", 64'(overrun), 64'(1));
    check("tmo_trigs", 64'(trig_cnt - t0), 64'(2));
    check("tmo_busy_n", 64'(busy_lens.size()), 64'(2));
    if (busy_lens.size() > 0) check("tmo_busy_len", 64'(busy_lens[0]), 64'(TMO + 1));

    // Clear both sticky flags
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    check("clr_ovr", 64'(overrun), 64'(0));
    check("clr_ackerr", 64'(ack_err), 64'(0));

    // Partial left word cut short by lrclk
    ack_en = 1'b1; sb_en = 1'b1; half = 4;
    held = dout_u; t0 = trig_cnt;
    send_word(1'b0, DS'($urandom), 10);
    send_word(1'b1, DS'($urandom), DS);
    repeat (50) @(negedge clk);
    check("part_trigs", 64'(trig_cnt - t0), 64'(0));
    check("part_data", 64'(dout_u), 64'(3));

    // Reset during bit 12; the remainder of that word must be dropped
    w = DS'($urandom);
    send_bit(1'b0, 1'($urandom));
    for (int i = 0; i < 11; i++) send_bit(1'b0, w[DS-1-i]);
    @(negedge clk); bclk = 1'b0; lrclk = 1'b0; sdata = w[DS-12];
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outputs_zero("inrst");
    end
    reset = 1'b1;
    t0 = trig_cnt;
    for (int i = 12; i < int'(DS); i++) send_bit(1'b0, w[DS-1-i]);
    repeat (30) @(negedge clk);
    check("post_rst_trigs", 64'(trig_cnt - t0), 64'(0));
    send_word(1'b1, DS'($urandom), DS);
    exp_q.push_back(24'h00ABCD);
    send_word(1'b0, 24'h00ABCD, DS);
    send_word(1'b1, DS'($urandom), 4);
    repeat (60) @(negedge clk);
    check("rst_word_data", 64'(dout_u), 64'h00ABCD);
    check("rst_word_trigs", 64'(trig_cnt - t0), 64'(1));

    // clear_flags held while an overrun happens: set must win for that cycle
    ack_en = 1'b0; sb_en = 1'b0; half = 2; ov_seen = 0;
    clear_flags = 1'b1;
    three_words();
    repeat (400) @(negedge clk);
    clear_flags = 1'b0;
    check("setwin_seen", 64'(ov_seen > 0), 64'(1));
    check("setwin_ovr_end", 64'(overrun), 64'(0));
    check("setwin_ackerr_end", 64'(ack_err), 64'(0));

    // Random words, random trailing bits and bclk rates
    ack_en = 1'b1; sb_en = 1'b1; busy_lens.delete(); t0 = trig_cnt;
    repeat (50) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      half = int'($urandom_range(2, 5));
      w = DS'($urandom);
      exp_q.push_back(w);
      send_word(1'b0, w, int'($urandom_range(DS, DS + 4)));
      send_word(1'b1, DS'($urandom), int'($urandom_range(1, DS + 4)));
    end
    repeat (60) @(negedge clk);
    check("rnd_trigs", 64'(trig_cnt - t0), 64'(8));
    check("rnd_left", 64'(exp_q.size()), 64'(0));
    check("rnd_ovr", 64'(overrun), 64'(0));
    check("rnd_ackerr", 64'(ack_err), 64'(0));
    check("rnd_busy_n", 64'(busy_lens.size()), 64'(8));
    foreach (busy_lens[i]) check("rnd_busy_len", 64'(busy_lens[i]), 64'(2 + HOLD + 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
